merge_rr_lock_dataless: RTL and testbench

//  Fair, handshake-stable merge for dataless elastic channels. It shares one

---
 rtl/merge_rr_lock_dataless_pkg.sv | 28 ++
 rtl/merge_rr_lock_dataless_rr_pointer_select.sv | 35 +++
 rtl/merge_rr_lock_dataless.sv | 90 +++++++++
 tb/tb_merge_rr_lock_dataless.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/merge_rr_lock_dataless_pkg.sv
// Shared definitions for the round-robin locking dataless merge.
// Provides the index-width helpers used for parameter legality checking
// and the per-cycle handshake event type used by the top level.
package merge_rr_lock_dataless_pkg;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Required width of the index port: at least one bit even for tiny merges.
  function automatic int index_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // What the output channel does this cycle.
  typedef enum logic [1:0] {
    EV_IDLE  = 2'd0,
    EV_XFER  = 2'd1,
    EV_STALL = 2'd2
  } ev_e;

endpackage

// File: rtl/merge_rr_lock_dataless_rr_pointer_select.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; gnt_idx falls back to ptr when nothing requests.
module rr_pointer_select
  import merge_rr_lock_dataless_pkg::*;
#(
  parameter int INPUTS      = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic [INPUTS-1:0]      req,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic [INDEX_WIDTH-1:0] gnt_idx,
  output logic                   any
);

  logic [INDEX_WIDTH-1:0] cand;

  // Scan ptr, ptr+1, ... modulo INPUTS and keep the first requester found.
  always_comb begin
    gnt_idx = ptr;
    any     = 1'b0;
    cand    = '0;
    for (int k = 0; k < INPUTS; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= INPUTS) j = j - INPUTS;
      cand = j[INDEX_WIDTH-1:0];
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/merge_rr_lock_dataless.sv
// Fair dataless merge: round-robin grant, locked while the output stalls.
// Latency: zero cycles, valid and index are combinational from ins_valid.
// Backpressure: a stalled grant is held so index never moves until accepted.
module merge_rr_lock_dataless
  import merge_rr_lock_dataless_pkg::*;
#(
  parameter int INPUTS      = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUTS-1:0]      ins_valid,
  output logic [INPUTS-1:0]      ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index
);

  if (INPUTS < 2 || INDEX_WIDTH != index_width(INPUTS)) begin : g_bad_cfg
    $error("merge_rr_lock_dataless: INDEX_WIDTH must equal max(1,clog2(INPUTS)), INPUTS>=2");
  end

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(INPUTS - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE  = INDEX_WIDTH'(1);

  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] held_q, held_d;
  logic                   locked_q, locked_d;
  logic [INDEX_WIDTH-1:0] sel_idx;
  logic                   sel_any;
  logic [INDEX_WIDTH-1:0] g;
  ev_e                    ev;

  rr_pointer_select #(
    .INPUTS      (INPUTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_sel (
    .req     (ins_valid),
    .ptr     (ptr_q),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  // Grant mux and output decode; outs_ready only reaches ins_ready.
  always_comb begin
    g          = locked_q ? held_q : sel_idx;
    outs_valid = locked_q ? ins_valid[held_q] : sel_any;
    index      = g;
    ins_ready  = '0;
    if (outs_valid && outs_ready) ins_ready[g] = 1'b1;
    if (!outs_valid)     ev = EV_IDLE;
    else if (outs_ready) ev = EV_XFER;
    else                 ev = EV_STALL;
  end

  // Next-state: advance past the winner on transfer, lock the winner on stall.
  always_comb begin
    ptr_d    = ptr_q;
    held_d   = held_q;
    locked_d = locked_q;
    case (ev)
      EV_XFER: begin
        ptr_d    = (g == LAST) ? '0 : g + ONE;
        locked_d = 1'b0;
      end
      EV_STALL: begin
        locked_d = 1'b1;
        held_d   = g;
      end
      default: begin
        // A retracted held request would otherwise leave the merge wedged.
        if (!ins_valid[held_q]) locked_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      held_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      held_q   <= held_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: tb/tb_merge_rr_lock_dataless.sv
// Directed and randomized checks of merge_rr_lock_dataless at INPUTS=2,3,4.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Three instances share clock and reset; idle instances see all-zero valids.
module tb_merge_rr_lock_dataless;

  logic clk;
  logic rst;

  logic [1:0] v2, rd2;  logic r2, ov2;  logic [0:0] ix2;
  logic [2:0] v3, rd3;  logic r3, ov3;  logic [1:0] ix3;
  logic [3:0] v4, rd4;  logic r4, ov4;  logic [1:0] ix4;

  int n_chk;
  int n_fail;
  int x4_in, x4_out;

  merge_rr_lock_dataless #(.INPUTS(2), .INDEX_WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .ins_valid(v2), .ins_ready(rd2),
    .outs_valid(ov2), .outs_ready(r2), .index(ix2));

  merge_rr_lock_dataless #(.INPUTS(3), .INDEX_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .ins_valid(v3), .ins_ready(rd3),
    .outs_valid(ov3), .outs_ready(r3), .index(ix3));

  merge_rr_lock_dataless #(.INPUTS(4), .INDEX_WIDTH(2)) dut4 (
    .clk(clk), .rst(rst), .ins_valid(v4), .ins_ready(rd4),
    .outs_valid(ov4), .outs_ready(r4), .index(ix4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Token accounting on the 4-input instance.
  always @(posedge clk) begin
    if (!rst) begin
      x4_in  <= x4_in + $countones(rd4 & v4);
      x4_out <= x4_out + ((ov4 && r4) ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] vld;
    logic       ordy;
    logic       e_ovld;
    logic [1:0] e_idx;
    logic [2:0] e_rdy;
  } vec_t;

  vec_t tbl [16];

  logic [2:0] prv_rdy;
  logic       prv_stall;
  logic [1:0] prv_idx;
  int         wait_cnt [3];

  initial begin
    n_chk = 0; n_fail = 0; x4_in = 0; x4_out = 0;
    rst = 1'b1;
    v2 = '0; r2 = 1'b0; v3 = '0; r3 = 1'b0; v4 = '0; r4 = 1'b0;

    // Fairness, wrap, idle fallback, lock and retraction on INPUTS=3.
    tbl[0]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[1]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010};
    tbl[2]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100};
    tbl[3]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[4]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010};
    tbl[5]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100};
    tbl[6]  = '{3'b100, 1'b1, 1'b1, 2'd2, 3'b100};
    tbl[7]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[8]  = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000};
    tbl[9]  = '{3'b101, 1'b1, 1'b1, 2'd2, 3'b100};
    tbl[10] = '{3'b011, 1'b0, 1'b1, 2'd0, 3'b000};
    tbl[11] = '{3'b111, 1'b0, 1'b1, 2'd0, 3'b000};
    tbl[12] = '{3'b110, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[13] = '{3'b110, 1'b1, 1'b1, 2'd1, 3'b010};
    tbl[14] = '{3'b011, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[15] = '{3'b110, 1'b1, 1'b1, 2'd1, 3'b010};

    // Reset held two cycles with both INPUTS=2 requesters valid.
    v2 = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ovld", 32'(ov2), 32'd1);
    chk("rst_idx",  32'(ix2), 32'd0);
    chk("rst_idle3_ovld", 32'(ov3), 32'd0);
    chk("rst_idle3_idx",  32'(ix3), 32'd0);
    chk("rst_idle3_rdy",  32'(rd3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    r2 = 1'b1;
    @(negedge clk);
    chk("post_rst_idx0", 32'(ix2), 32'd0);
    chk("post_rst_rdy0", 32'(rd2), 32'b01);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_idx1", 32'(ix2), 32'd1);
    chk("post_rst_rdy1", 32'(rd2), 32'b10);
    @(posedge clk); #1;

    // Stall lock on INPUTS=2: ptr is back at 0 here.
    v2 = 2'b10; r2 = 1'b0;
    @(negedge clk);
    chk("lock_c0_idx",  32'(ix2), 32'd1);
    chk("lock_c0_ovld", 32'(ov2), 32'd1);
    chk("lock_c0_rdy",  32'(rd2), 32'd0);
    @(posedge clk); #1;
    v2 = 2'b11;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("lock_c%0d_idx", c), 32'(ix2), 32'd1);
      chk($sformatf("lock_c%0d_rdy", c), 32'(rd2), 32'd0);
      @(posedge clk); #1;
    end
    r2 = 1'b1;
    @(negedge clk);
    chk("lock_c4_rdy", 32'(rd2), 32'b10);
    chk("lock_c4_idx", 32'(ix2), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lock_c5_idx", 32'(ix2), 32'd0);
    chk("lock_c5_rdy", 32'(rd2), 32'b01);
    @(posedge clk); #1;
    v2 = '0; r2 = 1'b0;

    // Vector table on INPUTS=3 (ptr=0, unlocked).
    for (int n = 0; n < 16; n++) begin
      v3 = tbl[n].vld;
      r3 = tbl[n].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_ovld", n), 32'(ov3), 32'(tbl[n].e_ovld));
      chk($sformatf("vec%0d_idx", n),  32'(ix3), 32'(tbl[n].e_idx));
      chk($sformatf("vec%0d_rdy", n),  32'(rd3), 32'(tbl[n].e_rdy));
      @(posedge clk); #1;
    end
    v3 = '0; r3 = 1'b0;

    // Reset in the middle of a stall on INPUTS=4.
    v4 = 4'b0100; r4 = 1'b0;
    @(negedge clk);
    chk("rms_stall_idx", 32'(ix4), 32'd2);
    chk("rms_stall_rdy", 32'(rd4), 32'd0);
    @(posedge clk); #1;
    v4 = 4'b0101;
    @(negedge clk);
    chk("rms_locked_idx", 32'(ix4), 32'd2);
    @(posedge clk); #1;
    v4 = 4'b0100; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v4 = 4'b1111;
    #1;
    chk("rms_ptr0_idx", 32'(ix4), 32'd0);
    v4 = 4'b0100; r4 = 1'b1;
    #1;
    chk("rms_after_ovld", 32'(ov4), 32'd1);
    chk("rms_after_idx",  32'(ix4), 32'd2);
    chk("rms_after_rdy",  32'(rd4), 32'b0100);
    @(posedge clk); #1;
    v4 = '0; r4 = 1'b0;
    @(negedge clk);
    chk("rms_tokens_in",  32'(x4_in),  32'd1);
    chk("rms_tokens_out", 32'(x4_out), 32'd1);
    @(posedge clk); #1;

    // Random stress on INPUTS=3: valids held until accepted.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prv_rdy = '0; prv_stall = 1'b0; prv_idx = '0;
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v3[i] || prv_rdy[i]) v3[i] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      end
      r3 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd_onehot0", 32'($onehot0(rd3)), 32'd1);
      chk("rnd_ovld", 32'(ov3), 32'(|v3));
      chk("rnd_rdy", 32'(rd3), (ov3 && r3) ? (32'd1 << ix3) : 32'd0);
      if (prv_stall) chk("rnd_stall_idx", 32'(ix3), 32'(prv_idx));
      if (ov3 && r3) begin
        for (int i = 0; i < 3; i++) begin
          if (i == int'(ix3)) begin
            wait_cnt[i] = 0;
          end else if (v3[i]) begin
            wait_cnt[i]++;
            chk($sformatf("rnd_starve%0d", i), 32'(wait_cnt[i] <= 2), 32'd1);
          end
        end
      end
      prv_rdy   = rd3;
      prv_stall = ov3 && !r3;
      prv_idx   = ix3;
      @(posedge clk); #1;
    end
    v3 = '0; r3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
